// File: rtl/draw_command_queue.sv
// -----------------------------------------------------------------------------
// draw_command_queue
//
// Purpose:
//   Buffers sprite draw commands (xOrigin, yOrigin, ROMId) from application
//   logic in a circular queue. It issues them one at a time to the DrawMif
//   sprite drawer through its draw/ready handshake.
//
//   The issued command's origin and ROM id stay registered and stable for the
//   whole draw. They change only on the edge that pops the next command.
//
// Handshake (DrawMif draw/ready):
//   - A command is issued only while ready=1 and the issuer is idle.
//   - draw is held high until ready=0 is sampled, which is DrawMif
//     acknowledging the start of the draw.
//   - draw then stays low until ready=1 is sampled again, which means the draw
//     has finished. Only after that can the next command issue.
//
// Ports:
//   clock, reset               rising-edge clock, async active-low reset
//   cmdX/cmdY/cmdROMId         command payload (8/9/4 bits)
//   cmdPush                    enqueue payload this cycle
//   cmdFlush                   discard all queued, not yet issued, commands
//   drawReady                  DrawMif ready
//   xOrigin/yOrigin/ROMId      issued command to DrawMif (registered)
//   draw                       DrawMif draw request (registered)
//   cmdFull                    queue holds DEPTH entries
//   cmdCount                   number of queued entries
//   overflow                   sticky: a push was dropped because queue full
//   busy                       issuer not idle, or queue not empty
//   dbgState                   issue FSM state (0 idle, 1 issue, 2 wait)
// -----------------------------------------------------------------------------
module draw_command_queue #(
  parameter int DEPTH     = 8,
  parameter int ADDR_BITS = 3
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [7:0]           cmdX,
  input  logic [8:0]           cmdY,
  input  logic [3:0]           cmdROMId,
  input  logic                 cmdPush,
  input  logic                 cmdFlush,
  input  logic                 drawReady,
  output logic [7:0]           xOrigin,
  output logic [8:0]           yOrigin,
  output logic [3:0]           ROMId,
  output logic                 draw,
  output logic                 cmdFull,
  output logic [ADDR_BITS:0]   cmdCount,
  output logic                 overflow,
  output logic                 busy,
  output logic [1:0]           dbgState
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2
  } state_t;

  localparam logic [ADDR_BITS:0] L_DEPTH = (ADDR_BITS+1)'(DEPTH);

  logic [20:0]          r_mem [DEPTH];
  logic [ADDR_BITS-1:0] r_wr_ptr;
  logic [ADDR_BITS-1:0] r_rd_ptr;
  logic [ADDR_BITS:0]   r_count;
  logic                 r_overflow;
  state_t               r_state;
  logic                 r_draw;
  logic [7:0]           r_x;
  logic [8:0]           r_y;
  logic [3:0]           r_rom;

  logic                 w_full;
  logic                 w_push;
  logic                 w_pop;
  logic [20:0]          w_head;

  // Fullness is judged on the registered count, before any pop on this edge.
  // A push that arrives on the same edge as the pop that frees a slot is
  // therefore still dropped.
  assign w_full = (r_count == L_DEPTH);
  // Flush takes priority over a push in the same cycle and discards it.
  assign w_push = cmdPush && !w_full && !cmdFlush;
  assign w_pop  = (r_state == S_IDLE) && (r_count != '0) && drawReady && !cmdFlush;
  assign w_head = r_mem[r_rd_ptr];

  // Payload storage is not reset. Entries are only read once the count says
  // they are valid.
  always_ff @(posedge clock) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= {cmdX, cmdY, cmdROMId};
    end
  end

  // Pointers, count and the sticky overflow flag.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else if (cmdFlush) begin
      // A push dropped in the same cycle as a flush does not set overflow.
      r_rd_ptr <= r_wr_ptr;
      r_count  <= '0;
    end else begin
      if (cmdPush && w_full) begin
        r_overflow <= 1'b1;
      end
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Issue FSM.
  // The origin registers load only on the pop edge, so they hold their value
  // through ISSUE, WAIT and any later idle time.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_draw  <= 1'b0;
      r_x     <= '0;
      r_y     <= '0;
      r_rom   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_draw <= 1'b0;
          if (w_pop) begin
            {r_x, r_y, r_rom} <= w_head;
            r_draw            <= 1'b1;
            r_state           <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          // DrawMif drops ready once it has latched the request.
          if (!drawReady) begin
            r_draw  <= 1'b0;
            r_state <= S_WAIT;
          end
        end
        S_WAIT: begin
          r_draw <= 1'b0;
          if (drawReady) begin
            r_state <= S_IDLE;
          end
        end
        default: begin
          r_draw  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign xOrigin  = r_x;
  assign yOrigin  = r_y;
  assign ROMId    = r_rom;
  assign draw     = r_draw;
  assign cmdFull  = w_full;
  assign cmdCount = r_count;
  assign overflow = r_overflow;
  assign busy     = (r_state != S_IDLE) || (r_count != '0);
  assign dbgState = r_state;

endmodule

// File: tb/tb_draw_command_queue.sv
module tb_draw_command_queue;

  localparam int DEPTH = 8;
  localparam int ADDR_BITS = 3;
  localparam int W = 21;

  // ---------------- clock / reset ----------------
  logic clock;
  logic reset;
  initial clock = 1'b0;
  always #5 clock = ~clock;

  logic [7:0]         cmdX;
  logic [8:0]         cmdY;
  logic [3:0]         cmdROMId;
  logic               cmdPush;
  logic               cmdFlush;
  logic               drawReady;
  logic [7:0]         xOrigin;
  logic [8:0]         yOrigin;
  logic [3:0]         ROMId;
  logic               draw;
  logic               cmdFull;
  logic [ADDR_BITS:0] cmdCount;
  logic               overflow;
  logic               busy;
  logic [1:0]         dbgState;

  draw_command_queue #(.DEPTH(DEPTH), .ADDR_BITS(ADDR_BITS)) dut (
    .clock(clock), .reset(reset),
    .cmdX(cmdX), .cmdY(cmdY), .cmdROMId(cmdROMId),
    .cmdPush(cmdPush), .cmdFlush(cmdFlush), .drawReady(drawReady),
    .xOrigin(xOrigin), .yOrigin(yOrigin), .ROMId(ROMId), .draw(draw),
    .cmdFull(cmdFull), .cmdCount(cmdCount), .overflow(overflow),
    .busy(busy), .dbgState(dbgState)
  );

  // ---------------- scoreboard / reference model ----------------
  logic [W-1:0] exp_q[$];     // commands queued, not yet issued
  logic [W-1:0] m_cur;        // command currently presented to DrawMif
  bit           m_draw;       // draw request is high
  bit           m_wait;       // request acknowledged, drawing not yet finished
  bit           m_ovf;
  int           m_issued;

  int checks;
  int errors;

  // DrawMif behavioural stand-in
  bit dm_force_low;
  bit dm_armed;
  int dm_left;
  int dm_len;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic reset_model();
    exp_q.delete();
    m_cur  = '0;
    m_draw = 0;
    m_wait = 0;
    m_ovf  = 0;
  endtask

  // Applies the rules for one rising edge, using the inputs the DUT sampled.
  task automatic model_edge();
    bit full_b;
    bit pop;
    if (!reset) begin
      reset_model();
    end else begin
      full_b = (exp_q.size() == DEPTH);
      pop = !m_draw && !m_wait && (exp_q.size() != 0) && drawReady && !cmdFlush;
      if (m_draw && !drawReady) begin
        m_draw = 0;
        m_wait = 1;
      end else if (m_wait && drawReady) begin
        m_wait = 0;
      end
      if (cmdFlush) begin
        exp_q.delete();
      end else begin
        if (pop) begin
          m_cur  = exp_q.pop_front();
          m_draw = 1;
          m_issued++;
        end
        if (cmdPush) begin
          if (full_b) m_ovf = 1;
          else exp_q.push_back({cmdX, cmdY, cmdROMId});
        end
      end
    end
  endtask

  task automatic compare_all();
    chk("draw",     draw,     m_draw);
    chk("xOrigin",  xOrigin,  m_cur[20:13]);
    chk("yOrigin",  yOrigin,  m_cur[12:4]);
    chk("ROMId",    ROMId,    m_cur[3:0]);
    chk("cmdCount", cmdCount, exp_q.size());
    chk("cmdFull",  cmdFull,  exp_q.size() == DEPTH);
    chk("overflow", overflow, m_ovf);
    chk("busy",     busy,     m_draw || m_wait || (exp_q.size() != 0));
  endtask

  // DrawMif: holds ready one more cycle after seeing draw, then drops it for
  // dm_len+1 cycles while "drawing".
  task automatic dm_update();
    if (dm_force_low) begin
      drawReady = 1'b0;
      dm_armed  = 0;
    end else if (dm_armed) begin
      drawReady = 1'b0;
      dm_left   = dm_len;
      dm_armed  = 0;
    end else if (drawReady && draw) begin
      dm_armed = 1;
    end else if (!drawReady) begin
      if (dm_left == 0) drawReady = 1'b1;
      else dm_left--;
    end
  endtask

  // ---------------- driver ----------------
  task automatic step(input bit push, input logic [W-1:0] cmd, input bit flush);
    cmdPush  = push;
    {cmdX, cmdY, cmdROMId} = cmd;
    cmdFlush = flush;
    @(posedge clock);
    model_edge();
    #1;
    compare_all();
    cmdPush  = 1'b0;
    cmdFlush = 1'b0;
    dm_update();
  endtask

  function automatic logic [W-1:0] rnd_cmd();
    return W'($urandom);
  endfunction

  task automatic drain(input int budget);
    int n;
    n = 0;
    while ((m_draw || m_wait || exp_q.size() != 0) && n < budget) begin
      step(0, '0, 0);
      n++;
    end
    chk("drain_timeout", n < budget, 1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int base;
    int n;
    logic [W-1:0] cmd_a;
    checks = 0;
    errors = 0;
    m_issued = 0;
    dm_force_low = 0;
    dm_armed = 0;
    dm_left = 0;
    dm_len = 1;
    reset = 1'b0;
    cmdPush = 0;
    cmdFlush = 0;
    cmdX = '0;
    cmdY = '0;
    cmdROMId = '0;
    drawReady = 1'b1;
    reset_model();
    #1;
    compare_all();
    chk("reset_state", dbgState, 0);
    #11 reset = 1'b1;

    // Single command 10/20/3
    step(1, {8'd10, 9'd20, 4'd3}, 0);
    chk("t1_count", cmdCount, 1);
    chk("t1_draw_before", draw, 0);
    step(0, '0, 0);
    chk("t1_draw", draw, 1);
    chk("t1_x", xOrigin, 10);
    chk("t1_y", yOrigin, 20);
    chk("t1_rom", ROMId, 3);
    drain(50);

    // Three back-to-back commands with long draws
    dm_len = 50;
    base = m_issued;
    for (int i = 0; i < 3; i++) step(1, rnd_cmd(), 0);
    drain(500);
    chk("t2_issued", m_issued - base, 3);

    // Fill to full while DrawMif is not ready
    dm_len = 2;
    dm_force_low = 1;
    drawReady = 1'b0;
    base = m_issued;
    for (int i = 0; i < DEPTH; i++) step(1, rnd_cmd(), 0);
    chk("t3_full", cmdFull, 1);
    chk("t3_count", cmdCount, DEPTH);
    step(1, rnd_cmd(), 0);
    chk("t3_overflow", overflow, 1);
    dm_force_low = 0;
    dm_left = 0;
    drain(300);
    chk("t3_issued", m_issued - base, DEPTH);

    // Random mix: wrap, simultaneous push/pop, occasional flush
    base = m_issued;
    for (int i = 0; i < 500; i++) begin
      dm_len = $urandom_range(0, 5);
      step($urandom_range(0, 99) < 45, rnd_cmd(), $urandom_range(0, 99) < 2);
    end
    drain(500);
    chk("t4_issued_ge20", (m_issued - base) >= 20, 1);

    // Flush while waiting with 5 queued
    dm_len = 30;
    cmd_a = {8'd77, 9'd300, 4'd9};
    base = m_issued;
    step(1, cmd_a, 0);
    n = 0;
    while (!m_draw && n < 10) begin step(0, '0, 0); n++; end
    chk("t5_issue_timeout", n < 10, 1);
    for (int i = 0; i < 5; i++) step(1, rnd_cmd(), 0);
    n = 0;
    while (!m_wait && n < 20) begin step(0, '0, 0); n++; end
    chk("t5_wait_timeout", n < 20, 1);
    chk("t5_count_before", cmdCount, 5);
    step(0, '0, 1);
    chk("t5_count_after", cmdCount, 0);
    chk("t5_x_kept", xOrigin, 77);
    chk("t5_y_kept", yOrigin, 300);
    chk("t5_rom_kept", ROMId, 9);
    drain(100);
    chk("t5_issued", m_issued - base, 1);

    // Reset during ISSUE
    dm_len = 20;
    step(1, rnd_cmd(), 0);
    n = 0;
    while (!m_draw && n < 10) begin step(0, '0, 0); n++; end
    chk("t6_issue_timeout", n < 10, 1);
    #2 reset = 1'b0;
    #1;
    reset_model();
    compare_all();
    chk("t6_state", dbgState, 0);
    drawReady = 1'b1;
    dm_armed = 0;
    dm_left = 0;
    step(0, '0, 0);
    reset = 1'b1;
    for (int i = 0; i < 10; i++) step(0, '0, 0);
    chk("t6_no_draw", draw, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/draw_command_queue.md
# draw_command_queue

Buffers sprite draw commands (origin coordinates plus ROM identifier) pushed by game/application logic, and issues them one at a time to the DrawMif sprite drawer using its `draw`/`ready` handshake. It sits directly upstream of DrawMif. Upstream logic can queue several sprites in consecutive cycles without tracking whether the LCD path is busy. The queue holds the issued command's `xOrigin`, `yOrigin` and `ROMId` stable for the whole draw, because DrawMif reads the origin throughout the operation.

## Interface
- `DEPTH`, 8: queue entries; power of two, ≥ 2.
- `ADDR_BITS`, 3: log2(`DEPTH`).

- `clock`  in  1  system clock, all logic on the rising edge.
- `reset`  in  1  asynchronous, active-low reset. Top level drives DrawMif's active-high reset from `~reset`.
- `cmdX`  in  8  requested sprite xOrigin.
- `cmdY`  in  9  requested sprite yOrigin.
- `cmdROMId`  in  4  requested sprite ROM.
- `cmdPush`  in  1  write {`cmdX`, `cmdY`, `cmdROMId`} into the queue this cycle.
- `cmdFlush`  in  1  discard all queued (not yet issued) entries.
- `drawReady`  in  1  DrawMif `ready`.
- `xOrigin`  out  8  to DrawMif; registered.
- `yOrigin`  out  9  to DrawMif; registered.
- `ROMId`  out  4  to DrawMif; registered.
- `draw`  out  1  to DrawMif; registered.
- `cmdFull`  out  1  count == `DEPTH`.
- `cmdCount`  out  `ADDR_BITS`+1  entries currently queued.
- `overflow`  out  1  sticky; set when a push was dropped. Cleared only by reset.
- `busy`  out  1  (state != IDLE) or (count != 0).

## Operation
- Storage: circular buffer of `DEPTH` × 21 bits, with write pointer, read pointer and count.
  - Pointers wrap modulo `DEPTH`.
  - count is `ADDR_BITS`+1 bits and never exceeds `DEPTH` or goes below 0.
- Push:
  - Accepted when `cmdPush`=1 and count<`DEPTH` at the clock edge.
  - When full, the push is dropped and `overflow`<=1. This applies even if a pop occurs in the same cycle.
- Pop: performed only by the issue FSM.
  - Push and pop in the same cycle: count is unchanged and both pointers advance.
- Flush:
  - Sets read pointer := write pointer and count := 0.
  - Has priority over a simultaneous push or pop; that push is also discarded and `overflow` is unchanged.
  - Does not affect the command already issued, and does not touch `draw` or the origin outputs.
- Issue FSM:
  - IDLE: `draw`=0. If count≠0 and `drawReady`=1 and not `cmdFlush`:
    - load head entry into `xOrigin`/`yOrigin`/`ROMId`;
    - set `draw`<=1;
    - pop;
    - go to ISSUE.
  - ISSUE: hold `draw`=1 until `drawReady`=0 is sampled, then `draw`<=0 and go to WAIT.
  - WAIT: `draw`=0. When `drawReady`=1 is sampled (draw finished), go to IDLE.
- `xOrigin`/`yOrigin`/`ROMId` change only on the IDLE pop edge. They are held through ISSUE, WAIT and any later IDLE period.
- After `draw` falls, DrawMif must see `draw` low before re-arming. This is guaranteed because WAIT→IDLE→next issue takes at least 2 cycles with `draw`=0.

## Timing
- Reset (`reset`=0): immediately and asynchronously, state=IDLE; pointers, count, `draw`, `xOrigin`, `yOrigin`, `ROMId`, `overflow` all 0. Hence `cmdFull`=0, `busy`=0.
- Reset mid-operation aborts the in-flight command and empties the queue. DrawMif is reset simultaneously.
- Push → count visible the cycle after the push edge.
- Push at edge k into an empty queue, FSM IDLE, `drawReady`=1:
  - edge k+1: pop; origin valid and `draw`=1.
  - DrawMif drops `ready` after edge k+2.
  - `draw` falls at edge k+3.
- Minimum `draw` pulse: 2 cycles. Zero-latency bypass of an empty queue is not supported.
- Back-to-back commands: the next issue occurs no earlier than 1 cycle after `drawReady` returns high.
- `cmdFull`/`cmdCount` reflect register state after the edge. A push on the same edge as the pop that frees a slot is still dropped.

## Test plan
- Reset with `drawReady`=1, then push {X=10, Y=20, ROMId=3} once → `draw` high 1 cycle after count=1, outputs 10/20/3. Model lowers ready 1 cycle later → `draw` low next edge. `busy` drops after ready returns high.
- Push 3 commands back-to-back while the model holds ready low for 50 cycles per draw → issued strictly in FIFO order. Each origin is stable from issue until ready returns high; `draw` is low ≥ 2 cycles between issues.
- Fill to 8 with model ready held 0 → `cmdFull`=1, `cmdCount`=8. A 9th push is dropped and `overflow`=1. After draining, exactly the 8 original commands are issued.
- Simultaneous push and pop with count=4 → count stays 4. Pointer wrap is exercised by 20 total commands, all issued in order.
- `cmdFlush` while in WAIT with 5 queued → count=0 next cycle and the current origin is unchanged. No further `draw` after ready returns.
- Assert `reset` low during ISSUE → `draw`, outputs and count are 0 immediately (asynchronously). After release, no `draw` occurs until a new push.
